mem_req_arbiter: RTL and testbench

Shares the single SRAM-like data-cache request port between the two MEM-stage lines of the dual-issue pipeline. It also tracks outstanding transactions in order and routes each `data_ok` response back to the owning line. Responses belonging to requests issued before an exception flush are silently dropped, so a flush never needs to retract an accepted request. It sits between the MEM-stage line datapaths and the data cache.

---
 rtl/mem_req_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_req_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like data-cache request port between the two MEM-stage lines and
// routes in-order data_ok responses back to the issuing line, dropping flushed ones.
module mem_req_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OUTS   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                l1_req,
  input  logic                l1_wr,
  input  logic [1:0]          l1_size,
  input  logic [ADDR_W-1:0]   l1_addr,
  input  logic [DATA_W-1:0]   l1_wdata,
  input  logic [DATA_W/8-1:0] l1_wstrb,
  input  logic                l2_req,
  input  logic                l2_wr,
  input  logic [1:0]          l2_size,
  input  logic [ADDR_W-1:0]   l2_addr,
  input  logic [DATA_W-1:0]   l2_wdata,
  input  logic [DATA_W/8-1:0] l2_wstrb,
  output logic                l1_grant,
  output logic                l2_grant,
  input  logic                excep_flush_i,
  output logic                cache_req,
  output logic                cache_wr,
  output logic [1:0]          cache_size,
  output logic [ADDR_W-1:0]   cache_addr,
  output logic [DATA_W-1:0]   cache_wdata,
  output logic [DATA_W/8-1:0] cache_wstrb,
  input  logic                cache_addr_ok,
  input  logic                cache_data_ok,
  input  logic [DATA_W-1:0]   cache_rdata,
  output logic                resp_valid,
  output logic                resp_line,
  output logic                resp_wr,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                busy,
  output logic                err_o
);

  localparam int unsigned CNT_W = $clog2(OUTS + 1);
  localparam int unsigned PTR_W = (OUTS > 1) ? $clog2(OUTS) : 1;

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e           state_q;
  logic             owner_q;
  logic             flush_pend_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [OUTS-1:0]  tag_line_q, tag_wr_q, tag_disc_q;

  logic full, capture, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(OUTS));
  assign capture = (state_q == StIdle) && (l1_req || l2_req) && !excep_flush_i && !full;
  assign push    = (state_q == StReq) && cache_addr_ok;
  assign pop     = cache_data_ok && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Request FSM and registered payload; the payload stays stable for the whole REQ phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      cache_wr     <= 1'b0;
      cache_size   <= '0;
      cache_addr   <= '0;
      cache_wdata  <= '0;
      cache_wstrb  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (capture) begin
            state_q      <= StReq;
            owner_q      <= !l1_req;
            flush_pend_q <= 1'b0;
            cache_wr     <= l1_req ? l1_wr    : l2_wr;
            cache_size   <= l1_req ? l1_size  : l2_size;
            cache_addr   <= l1_req ? l1_addr  : l2_addr;
            cache_wdata  <= l1_req ? l1_wdata : l2_wdata;
            cache_wstrb  <= l1_req ? l1_wstrb : l2_wstrb;
          end
        end
        StReq: begin
          if (cache_addr_ok) begin
            state_q      <= StIdle;
            flush_pend_q <= 1'b0;
          end else if (excep_flush_i) begin
            flush_pend_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // In-order tag FIFO for accepted requests awaiting data_ok.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      tag_line_q <= '0;
      tag_wr_q   <= '0;
      tag_disc_q <= '0;
      err_o      <= 1'b0;
    end else begin
      count_q <= count_d;
      // Marking unused slots too is harmless: a push always rewrites its slot's bit.
      if (excep_flush_i) begin
        tag_disc_q <= '1;
      end
      if (push) begin
        tag_line_q[tail_q] <= owner_q;
        tag_wr_q[tail_q]   <= cache_wr;
        tag_disc_q[tail_q] <= excep_flush_i || flush_pend_q;
        tail_q             <= ptr_inc(tail_q);
      end
      if (pop) begin
        head_q <= ptr_inc(head_q);
      end
      if (cache_data_ok && (count_q == '0)) begin
        err_o <= 1'b1;
      end
    end
  end

  assign cache_req  = (state_q == StReq);
  assign l1_grant   = push && !owner_q;
  assign l2_grant   = push && owner_q;
  assign resp_valid = pop && !tag_disc_q[head_q] && !excep_flush_i;
  assign resp_line  = pop && tag_line_q[head_q];
  assign resp_wr    = pop && tag_wr_q[head_q];
  assign resp_rdata = cache_rdata;
  assign busy       = (count_q != '0) || cache_req;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based behavioural model.
module tb_mem_req_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int OUTS   = 2;
  localparam int SW     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              l1_req, l1_wr, l2_req, l2_wr;
  logic [1:0]        l1_size, l2_size;
  logic [ADDR_W-1:0] l1_addr, l2_addr;
  logic [DATA_W-1:0] l1_wdata, l2_wdata;
  logic [SW-1:0]     l1_wstrb, l2_wstrb;
  logic              l1_grant, l2_grant, excep_flush_i;
  logic              cache_req, cache_wr;
  logic [1:0]        cache_size;
  logic [ADDR_W-1:0] cache_addr;
  logic [DATA_W-1:0] cache_wdata;
  logic [SW-1:0]     cache_wstrb;
  logic              cache_addr_ok, cache_data_ok;
  logic [DATA_W-1:0] cache_rdata;
  logic              resp_valid, resp_line, resp_wr, busy, err_o;
  logic [DATA_W-1:0] resp_rdata;

  always #5 clk = ~clk;

  mem_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUTS(OUTS)) dut (
    .clk(clk), .rst_n(rst_n),
    .l1_req(l1_req), .l1_wr(l1_wr), .l1_size(l1_size), .l1_addr(l1_addr),
    .l1_wdata(l1_wdata), .l1_wstrb(l1_wstrb),
    .l2_req(l2_req), .l2_wr(l2_wr), .l2_size(l2_size), .l2_addr(l2_addr),
    .l2_wdata(l2_wdata), .l2_wstrb(l2_wstrb),
    .l1_grant(l1_grant), .l2_grant(l2_grant), .excep_flush_i(excep_flush_i),
    .cache_req(cache_req), .cache_wr(cache_wr), .cache_size(cache_size),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_wstrb(cache_wstrb),
    .cache_addr_ok(cache_addr_ok), .cache_data_ok(cache_data_ok), .cache_rdata(cache_rdata),
    .resp_valid(resp_valid), .resp_line(resp_line), .resp_wr(resp_wr),
    .resp_rdata(resp_rdata), .busy(busy), .err_o(err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: one pending request slot plus a queue of accepted transactions.
  typedef struct packed {logic line; logic wr; logic disc;} ent_t;
  ent_t               mq[$];
  logic               m_have, m_line, m_flush, m_err, m_wr;
  logic [1:0]         m_size;
  logic [ADDR_W-1:0]  m_addr;
  logic [DATA_W-1:0]  m_wdata;
  logic [SW-1:0]      m_wstrb;
  logic               last_g1, last_g2;

  task automatic model_reset();
    mq.delete();
    m_have = 0; m_line = 0; m_flush = 0; m_err = 0;
    last_g1 = 0; last_g2 = 0;
  endtask

  task automatic idle_inputs();
    l1_req = 0; l1_wr = 0; l1_size = 0; l1_addr = 0; l1_wdata = 0; l1_wstrb = 0;
    l2_req = 0; l2_wr = 0; l2_size = 0; l2_addr = 0; l2_wdata = 0; l2_wstrb = 0;
    excep_flush_i = 0; cache_addr_ok = 0; cache_data_ok = 0; cache_rdata = 0;
  endtask

  // Called at posedge+1 after inputs are driven; checks outputs against the model.
  task automatic settle();
    int   sz;
    logic pop;
    ent_t h;
    #2;
    sz  = mq.size();
    pop = cache_data_ok && (sz > 0);
    h   = (sz > 0) ? mq[0] : '0;
    last_g1 = m_have && cache_addr_ok && !m_line;
    last_g2 = m_have && cache_addr_ok && m_line;
    check_eq("cache_req", cache_req, m_have);
    if (m_have) begin
      check_eq("payload", {cache_wr, cache_size, cache_addr, cache_wdata, cache_wstrb},
               {m_wr, m_size, m_addr, m_wdata, m_wstrb});
    end
    check_eq("l1_grant", l1_grant, last_g1);
    check_eq("l2_grant", l2_grant, last_g2);
    check_eq("resp_valid", resp_valid, pop && !h.disc && !excep_flush_i);
    check_eq("resp_line", resp_line, pop && h.line);
    check_eq("resp_wr", resp_wr, pop && h.wr);
    check_eq("resp_rdata", resp_rdata, cache_rdata);
    check_eq("busy", busy, m_have || (sz > 0));
    check_eq("err_o", err_o, m_err);
  endtask

  // Advances one clock and updates the model from the inputs of the cycle just ended.
  task automatic advance();
    int   sz;
    ent_t e;
    @(posedge clk);
    #1;
    sz = mq.size();
    if (cache_data_ok && sz == 0) m_err = 1;
    if (excep_flush_i) foreach (mq[i]) mq[i].disc = 1;
    if (cache_data_ok && sz > 0) void'(mq.pop_front());
    if (m_have) begin
      if (cache_addr_ok) begin
        e.line = m_line; e.wr = m_wr; e.disc = excep_flush_i || m_flush;
        mq.push_back(e);
        m_have = 0; m_flush = 0;
      end else if (excep_flush_i) begin
        m_flush = 1;
      end
    end else if ((l1_req || l2_req) && !excep_flush_i && sz < OUTS) begin
      m_have = 1; m_flush = 0; m_line = !l1_req;
      m_wr    = l1_req ? l1_wr    : l2_wr;
      m_size  = l1_req ? l1_size  : l2_size;
      m_addr  = l1_req ? l1_addr  : l2_addr;
      m_wdata = l1_req ? l1_wdata : l2_wdata;
      m_wstrb = l1_req ? l1_wstrb : l2_wstrb;
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 0;
    #1;
    check_eq("rst_outputs",
             {cache_req, l1_grant, l2_grant, resp_valid, resp_line, resp_wr, busy, err_o}, 8'h0);
    check_eq("rst_payload", {cache_wr, cache_size, cache_addr, cache_wdata, cache_wstrb}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Single load with immediate addr_ok.
    l1_req = 1; l1_addr = 32'h1000; l1_size = 2; cache_addr_ok = 1;
    settle(); check_eq("sl_c0_req", cache_req, 1'b0); advance();
    settle(); check_eq("sl_c1_req", cache_req, 1'b1); check_eq("sl_c1_gnt", l1_grant, 1'b1);
    advance();
    l1_req = 0; cache_addr_ok = 0;
    settle(); advance();
    cache_data_ok = 1; cache_rdata = 32'hDEADBEEF;
    settle();
    check_eq("sl_resp", {resp_valid, resp_line, resp_rdata}, {1'b1, 1'b0, 32'hDEADBEEF});
    advance();
    cache_data_ok = 0;

    // Priority: line1 first, line2 request appears in cycle 3.
    l1_req = 1; l1_addr = 32'h2000; l2_req = 1; l2_addr = 32'h3000; l2_wr = 1;
    cache_addr_ok = 1;
    settle(); advance();
    settle(); check_eq("pr_c1_gnt", {l1_grant, l2_grant}, 2'b10); advance();
    l1_req = 0;
    settle(); check_eq("pr_c2_bubble", cache_req, 1'b0); advance();
    settle(); check_eq("pr_c3_gnt", {cache_req, l2_grant, cache_addr}, {2'b11, 32'h3000});
    advance();
    l2_req = 0; cache_addr_ok = 0; cache_data_ok = 1;
    settle(); check_eq("pr_resp0", {resp_valid, resp_line}, 2'b10); advance();
    settle(); check_eq("pr_resp1", {resp_valid, resp_line, resp_wr}, 3'b111); advance();
    cache_data_ok = 0;

    // Flush during REQ with addr_ok delayed.
    l1_req = 1; l1_addr = 32'h4444; l2_wr = 0;
    settle(); advance();
    excep_flush_i = 1;
    settle(); advance();
    excep_flush_i = 0;
    settle(); advance();
    cache_addr_ok = 1;
    settle(); check_eq("fl_held", {l1_grant, cache_addr}, {1'b1, 32'h4444}); advance();
    l1_req = 0; cache_addr_ok = 0; cache_data_ok = 1;
    settle(); check_eq("fl_dropped", resp_valid, 1'b0); advance();
    cache_data_ok = 0;

    // Protocol error then asynchronous reset mid-cycle.
    cache_data_ok = 1;
    settle(); advance();
    cache_data_ok = 0;
    settle(); check_eq("err_set", err_o, 1'b1); advance();
    settle(); check_eq("err_sticky", err_o, 1'b1);
    rst_n = 0;
    #1;
    check_eq("err_async_clr", {err_o, busy}, 2'b00);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;

    // Randomized traffic; each line holds its request until granted.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (l1_req && last_g1) l1_req = 0;
      if (l2_req && last_g2) l2_req = 0;
      if (!l1_req && $urandom_range(0, 2) == 0) begin
        l1_req = 1; l1_wr = 1'($urandom); l1_size = 2'($urandom_range(0, 2));
        l1_addr = $urandom; l1_wdata = $urandom; l1_wstrb = 4'($urandom);
      end
      if (!l2_req && $urandom_range(0, 2) == 0) begin
        l2_req = 1; l2_wr = 1'($urandom); l2_size = 2'($urandom_range(0, 2));
        l2_addr = $urandom; l2_wdata = $urandom; l2_wstrb = 4'($urandom);
      end
      excep_flush_i = ($urandom_range(0, 11) == 0);
      cache_addr_ok = 1'($urandom);
      cache_data_ok = (mq.size() > 0) ? ($urandom_range(0, 2) == 0)
                                      : ($urandom_range(0, 39) == 0);
      cache_rdata   = $urandom;
      settle();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
